seq_cla_add_ctrl: RTL and testbench

//  Multi-cycle sequencer that time-shares one 4-bit augmented CLA slice to add WIDTH-bit operands, LS nibble first.

---
 rtl/seq_add_pkg.sv | 18 +
 rtl/CLA_4bit_aug.sv | 37 +++
 rtl/seq_cla_add_ctrl.sv | 180 ++++++++++++++++++
 tb/tb_seq_cla_add_ctrl.sv | 237 +++++++++++++++++++++++
 4 files changed

// File: rtl/seq_add_pkg.sv
// Shared definitions for the time-shared CLA adder sequencer: slice width,
// FSM state encoding and the block carry-out helper.
package seq_add_pkg;

  localparam int SLICE_W = 4;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    RUN  = 2'b01,
    DONE = 2'b10
  } state_t;

  // Carry out of a slice from its block propagate/generate and carry-in.
  function automatic logic slice_carry(input logic g, input logic p, input logic c);
    return g | (p & c);
  endfunction

endpackage

// File: rtl/CLA_4bit_aug.sv
// 4-bit carry-lookahead slice augmented with block propagate/generate outputs
// so a caller can chain slices using P/G alone.
module CLA_4bit_aug
  import seq_add_pkg::*;
(
  input  logic [SLICE_W-1:0] a,
  input  logic [SLICE_W-1:0] b,
  input  logic               c_in,
  output logic [SLICE_W-1:0] sum,
  output logic               p,
  output logic               g,
  output logic               c_out
);

  logic [SLICE_W-1:0] prop_s;
  logic [SLICE_W-1:0] gen_s;
  logic [SLICE_W-1:0] carry_s;

  assign prop_s = a ^ b;
  assign gen_s  = a & b;

  // Internal lookahead carries into each bit.
  assign carry_s[0] = c_in;
  assign carry_s[1] = gen_s[0] | (prop_s[0] & c_in);
  assign carry_s[2] = gen_s[1] | (prop_s[1] & gen_s[0]) | (prop_s[1] & prop_s[0] & c_in);
  assign carry_s[3] = gen_s[2] | (prop_s[2] & gen_s[1]) | (prop_s[2] & prop_s[1] & gen_s[0])
                    | (prop_s[2] & prop_s[1] & prop_s[0] & c_in);

  // Block propagate/generate, independent of carry-in.
  assign p = &prop_s;
  assign g = gen_s[3] | (prop_s[3] & gen_s[2]) | (prop_s[3] & prop_s[2] & gen_s[1])
           | (prop_s[3] & prop_s[2] & prop_s[1] & gen_s[0]);

  assign c_out = slice_carry(g, p, c_in);
  assign sum   = prop_s ^ carry_s;

endmodule

// File: rtl/seq_cla_add_ctrl.sv
// Multi-cycle adder: one CLA_4bit_aug slice is reused for every nibble,
// LS nibble first, one nibble per clock. The inter-slice carry is rebuilt from
// the slice's block P/G and held in a register.
// Optional feature macro: SEQ_ADD_SUB_EN adds a 'sub' input (a - b).
module seq_cla_add_ctrl
  import seq_add_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             c_in,
`ifdef SEQ_ADD_SUB_EN
  input  logic             sub,
`endif
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             c_out,
  output logic             ovf
);

  localparam int NSLICE = WIDTH / SLICE_W;
  localparam int K_W    = (NSLICE > 1) ? $clog2(NSLICE) : 1;

  if (((WIDTH % SLICE_W) != 0) || (WIDTH < 8)) begin : g_width_check
    $error("seq_cla_add_ctrl: WIDTH must be a multiple of 4 and >= 8");
  end

  state_t             state_r;
  state_t             state_nxt;
  logic [K_W-1:0]     k_r;
  logic               carry_r;
  logic [WIDTH-1:0]   opa_r;
  logic [WIDTH-1:0]   opb_r;
  logic [WIDTH-1:0]   sum_r;
  logic               c_out_r;
  logic               ovf_r;
  logic               out_valid_r;

  logic [WIDTH-1:0]   b_eff_s;
  logic               cin_eff_s;
  logic               accept_s;
  logic               take_s;
  logic               last_s;
  logic [SLICE_W-1:0] nib_a_s;
  logic [SLICE_W-1:0] nib_b_s;
  logic [SLICE_W-1:0] slice_sum_s;
  logic               slice_p_s;
  logic               slice_g_s;
  logic               slice_c_out_unused;
  logic               carry_nxt_s;

`ifdef SEQ_ADD_SUB_EN
  // Subtract as a + ~b + 1; c_in is ignored when subtracting.
  always_comb begin
    if (sub) begin
      b_eff_s   = ~b;
      cin_eff_s = 1'b1;
    end else begin
      b_eff_s   = b;
      cin_eff_s = c_in;
    end
  end
`else
  assign b_eff_s   = b;
  assign cin_eff_s = c_in;
`endif

  assign in_ready = (state_r == IDLE);
  assign last_s   = (state_r == RUN) && (k_r == K_W'(NSLICE - 1));

  // Current nibble of each latched operand.
  assign nib_a_s = opa_r[k_r*SLICE_W +: SLICE_W];
  assign nib_b_s = opb_r[k_r*SLICE_W +: SLICE_W];

  CLA_4bit_aug u_slice (
    .a     (nib_a_s),
    .b     (nib_b_s),
    .c_in  (carry_r),
    .sum   (slice_sum_s),
    .p     (slice_p_s),
    .g     (slice_g_s),
    .c_out (slice_c_out_unused)
  );

  assign carry_nxt_s = slice_carry(slice_g_s, slice_p_s, carry_r);

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r <= IDLE;
    end else begin
      state_r <= state_nxt;
    end
  end

  // Next-state logic and handshake strobes; unknown encodings fall back to IDLE.
  always_comb begin
    state_nxt = state_r;
    accept_s  = 1'b0;
    take_s    = 1'b0;
    case (state_r)
      IDLE: begin
        if (in_valid) begin
          state_nxt = RUN;
          accept_s  = 1'b1;
        end else begin
          state_nxt = IDLE;
        end
      end
      RUN: begin
        if (last_s) begin
          state_nxt = DONE;
        end else begin
          state_nxt = RUN;
        end
      end
      DONE: begin
        if (out_ready) begin
          state_nxt = IDLE;
          take_s    = 1'b1;
        end else begin
          state_nxt = DONE;
        end
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

  // Operand latch, per-nibble accumulation and result/flag registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      k_r         <= {K_W{1'b0}};
      carry_r     <= 1'b0;
      opa_r       <= {WIDTH{1'b0}};
      opb_r       <= {WIDTH{1'b0}};
      sum_r       <= {WIDTH{1'b0}};
      c_out_r     <= 1'b0;
      ovf_r       <= 1'b0;
      out_valid_r <= 1'b0;
    end else if (accept_s) begin
      opa_r   <= a;
      opb_r   <= b_eff_s;
      carry_r <= cin_eff_s;
      k_r     <= {K_W{1'b0}};
      sum_r   <= {WIDTH{1'b0}};
    end else if (state_r == RUN) begin
      sum_r[k_r*SLICE_W +: SLICE_W] <= slice_sum_s;
      carry_r                       <= carry_nxt_s;
      if (last_s) begin
        k_r         <= {K_W{1'b0}};
        c_out_r     <= carry_nxt_s;
        ovf_r       <= (opa_r[WIDTH-1] == opb_r[WIDTH-1]) &&
                       (slice_sum_s[SLICE_W-1] != opa_r[WIDTH-1]);
        out_valid_r <= 1'b1;
      end else begin
        k_r <= k_r + K_W'(1);
      end
    end else if (take_s) begin
      out_valid_r <= 1'b0;
    end else if ((state_r != IDLE) && (state_r != DONE)) begin
      // Illegal encoding: drop any stale result while the FSM recovers.
      out_valid_r <= 1'b0;
      k_r         <= {K_W{1'b0}};
    end
  end

  assign sum       = sum_r;
  assign c_out     = c_out_r;
  assign ovf       = ovf_r;
  assign out_valid = out_valid_r;

endmodule

// File: tb/tb_seq_cla_add_ctrl.sv
// Self-checking bench for seq_cla_add_ctrl (WIDTH=32) with an expected-result
// queue filled at stimulus time and drained when results appear.
module tb_seq_cla_add_ctrl;
  import seq_add_pkg::*;

  localparam int WIDTH = 32;
  localparam int LAT   = WIDTH / SLICE_W;

  logic             clk = 1'b0;
  logic             rst_n;
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             c_in;
  logic             sub;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] sum;
  logic             c_out;
  logic             ovf;

  typedef struct {
    logic [WIDTH-1:0] sum;
    logic             c_out;
    logic             ovf;
  } exp_t;

  exp_t sb[$];
  int   n_checks = 0;
  int   n_pass   = 0;

  always #5 clk = ~clk;

  seq_cla_add_ctrl #(.WIDTH(WIDTH)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .b         (b),
    .c_in      (c_in),
`ifdef SEQ_ADD_SUB_EN
    .sub       (sub),
`endif
    .out_valid (out_valid),
    .out_ready (out_ready),
    .sum       (sum),
    .c_out     (c_out),
    .ovf       (ovf)
  );

  // Reference model: plain wide addition.
  task automatic push_expected(input logic [WIDTH-1:0] xa, input logic [WIDTH-1:0] xb,
                               input logic xc, input logic xs);
    logic [WIDTH:0]   full;
    logic [WIDTH-1:0] be;
    logic             ci;
    exp_t             e;
    be     = xs ? ~xb : xb;
    ci     = xs ? 1'b1 : xc;
    full   = {1'b0, xa} + {1'b0, be} + {{WIDTH{1'b0}}, ci};
    e.sum  = full[WIDTH-1:0];
    e.c_out = full[WIDTH];
    e.ovf  = (xa[WIDTH-1] == be[WIDTH-1]) && (full[WIDTH-1] != xa[WIDTH-1]);
    sb.push_back(e);
  endtask

  // Drive one operation, optionally hold off the consumer, then take the result.
  task automatic run_op(input logic [WIDTH-1:0] xa, input logic [WIDTH-1:0] xb,
                        input logic xc, input logic xs, input int hold,
                        output logic [WIDTH-1:0] gs, output logic gc, output logic go,
                        output int lat, output logic stable,
                        output logic v_after, output logic r_after);
    int t;
    push_expected(xa, xb, xc, xs);
    t = 0;
    while (!in_ready && t < 50) begin
      @(posedge clk); #1;
      t++;
    end
    a = xa; b = xb; c_in = xc; sub = xs; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    a = $urandom; b = $urandom; c_in = 1'($urandom_range(1));
    lat = -1;
    for (int i = 1; i <= 40; i++) begin
      @(posedge clk); #1;
      if (out_valid === 1'b1) begin
        lat = i;
        break;
      end
    end
    gs = sum; gc = c_out; go = ovf;
    stable = 1'b1;
    for (int i = 0; i < hold; i++) begin
      in_valid = 1'b1; a = $urandom; b = $urandom;
      @(posedge clk); #1;
      if (!(out_valid === 1'b1 && in_ready === 1'b0 && sum === gs &&
            c_out === gc && ovf === go)) stable = 1'b0;
    end
    in_valid = 1'b0; out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    v_after = out_valid;
    r_after = in_ready;
  endtask

  task automatic test_reset();
    logic spurious;
    rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    a = '0; b = '0; c_in = 1'b0; sub = 1'b0;
    #12;
    n_checks++; if (out_valid !== 1'b0) $display("FAIL reset_out_valid: got %b expected 0", out_valid); else n_pass++;
    n_checks++; if (sum !== 32'h0) $display("FAIL reset_sum: got %h expected 00000000", sum); else n_pass++;
    n_checks++; if (in_ready !== 1'b1) $display("FAIL reset_in_ready: got %b expected 1", in_ready); else n_pass++;
    @(posedge clk); #1;
    rst_n = 1'b1;
    spurious = 1'b0;
    repeat (4) begin
      @(posedge clk); #1;
      if (out_valid !== 1'b0 || in_ready !== 1'b1) spurious = 1'b1;
    end
    n_checks++; if (spurious !== 1'b0) $display("FAIL reset_release_idle: got spurious=%b expected 0", spurious); else n_pass++;
  endtask

  task automatic test_add_vectors();
    logic [WIDTH-1:0] va [6];
    logic [WIDTH-1:0] vb [6];
    logic             vc [6];
    logic [WIDTH-1:0] gs;
    logic gc, go, st, va_after, ra_after;
    int   lat;
    exp_t e;
    va[0] = 32'h0000000F; vb[0] = 32'h00000001; vc[0] = 1'b0;
    va[1] = 32'hFFFFFFFF; vb[1] = 32'h00000001; vc[1] = 1'b0;
    va[2] = 32'h7FFFFFFF; vb[2] = 32'h00000001; vc[2] = 1'b0;
    va[3] = 32'h80000000; vb[3] = 32'h80000000; vc[3] = 1'b0;
    va[4] = 32'hFFFFFFFF; vb[4] = 32'h00000000; vc[4] = 1'b1;
    va[5] = 32'h9ABCDEF0; vb[5] = 32'h6543210F; vc[5] = 1'b1;
    for (int i = 0; i < 6; i++) begin
      run_op(va[i], vb[i], vc[i], 1'b0, 0, gs, gc, go, lat, st, va_after, ra_after);
      e = sb.pop_front();
      n_checks++; if (gs !== e.sum) $display("FAIL add_sum[%0d]: got %h expected %h", i, gs, e.sum); else n_pass++;
      n_checks++; if (gc !== e.c_out) $display("FAIL add_c_out[%0d]: got %b expected %b", i, gc, e.c_out); else n_pass++;
      n_checks++; if (go !== e.ovf) $display("FAIL add_ovf[%0d]: got %b expected %b", i, go, e.ovf); else n_pass++;
      n_checks++; if (lat !== LAT) $display("FAIL add_latency[%0d]: got %0d expected %0d", i, lat, LAT); else n_pass++;
      n_checks++; if (va_after !== 1'b0) $display("FAIL add_valid_drop[%0d]: got %b expected 0", i, va_after); else n_pass++;
    end
  endtask

  task automatic test_backpressure();
    logic [WIDTH-1:0] gs;
    logic gc, go, st, va_after, ra_after;
    int   lat;
    exp_t e;
    run_op(32'h0F0F0F0F, 32'h01010101, 1'b0, 1'b0, 5, gs, gc, go, lat, st, va_after, ra_after);
    e = sb.pop_front();
    n_checks++; if (st !== 1'b1) $display("FAIL bp_stable: got %b expected 1", st); else n_pass++;
    n_checks++; if (gs !== e.sum) $display("FAIL bp_sum: got %h expected %h", gs, e.sum); else n_pass++;
    n_checks++; if (va_after !== 1'b0) $display("FAIL bp_valid_drop: got %b expected 0", va_after); else n_pass++;
    n_checks++; if (ra_after !== 1'b1) $display("FAIL bp_idle_after_take: got %b expected 1", ra_after); else n_pass++;
    run_op(32'h00000100, 32'h00000023, 1'b1, 1'b0, 0, gs, gc, go, lat, st, va_after, ra_after);
    e = sb.pop_front();
    n_checks++; if (gs !== e.sum) $display("FAIL bp_next_sum: got %h expected %h", gs, e.sum); else n_pass++;
    n_checks++; if (lat !== LAT) $display("FAIL bp_next_latency: got %0d expected %0d", lat, LAT); else n_pass++;
  endtask

  task automatic test_reset_mid_op();
    logic [WIDTH-1:0] gs;
    logic gc, go, st, va_after, ra_after, saw;
    int   lat;
    exp_t e;
    a = 32'h12345678; b = 32'h11111111; c_in = 1'b0; sub = 1'b0; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    rst_n = 1'b0;
    #2;
    n_checks++; if (out_valid !== 1'b0) $display("FAIL midrst_out_valid: got %b expected 0", out_valid); else n_pass++;
    n_checks++; if (in_ready !== 1'b1) $display("FAIL midrst_in_ready: got %b expected 1", in_ready); else n_pass++;
    rst_n = 1'b1;
    saw = 1'b0;
    repeat (12) begin
      @(posedge clk); #1;
      if (out_valid !== 1'b0) saw = 1'b1;
    end
    n_checks++; if (saw !== 1'b0) $display("FAIL midrst_no_result: got %b expected 0", saw); else n_pass++;
    run_op(32'h00000001, 32'h00000002, 1'b0, 1'b0, 0, gs, gc, go, lat, st, va_after, ra_after);
    e = sb.pop_front();
    n_checks++; if (gs !== e.sum) $display("FAIL midrst_next_sum: got %h expected %h", gs, e.sum); else n_pass++;
    n_checks++; if (lat !== LAT) $display("FAIL midrst_next_latency: got %0d expected %0d", lat, LAT); else n_pass++;
  endtask

  task automatic test_back_to_back();
    logic [WIDTH-1:0] gs;
    logic gc, go, st, va_after, ra_after;
    int   lat;
    exp_t e;
    for (int i = 0; i < 4; i++) begin
      run_op($urandom, $urandom, 1'($urandom_range(1)), 1'b0, 0, gs, gc, go, lat, st, va_after, ra_after);
      e = sb.pop_front();
      n_checks++; if (gs !== e.sum) $display("FAIL b2b_sum[%0d]: got %h expected %h", i, gs, e.sum); else n_pass++;
      n_checks++; if ({gc, go} !== {e.c_out, e.ovf}) $display("FAIL b2b_flags[%0d]: got %b%b expected %b%b", i, gc, go, e.c_out, e.ovf); else n_pass++;
      n_checks++; if (ra_after !== 1'b1) $display("FAIL b2b_ready[%0d]: got %b expected 1", i, ra_after); else n_pass++;
    end
  endtask

`ifdef SEQ_ADD_SUB_EN
  task automatic test_sub();
    logic [WIDTH-1:0] gs;
    logic gc, go, st, va_after, ra_after;
    int   lat;
    exp_t e;
    run_op(32'h00000005, 32'h00000007, 1'b0, 1'b1, 0, gs, gc, go, lat, st, va_after, ra_after);
    e = sb.pop_front();
    n_checks++; if (gs !== e.sum) $display("FAIL sub_sum: got %h expected %h", gs, e.sum); else n_pass++;
    n_checks++; if (gc !== e.c_out) $display("FAIL sub_c_out: got %b expected %b", gc, e.c_out); else n_pass++;
    n_checks++; if (go !== e.ovf) $display("FAIL sub_ovf: got %b expected %b", go, e.ovf); else n_pass++;
  endtask
`endif

  initial begin
    test_reset();
    test_add_vectors();
    test_backpressure();
    test_reset_mid_op();
    test_back_to_back();
`ifdef SEQ_ADD_SUB_EN
    test_sub();
`endif
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
